// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two cores.
// Loads are tagged through a fixed-latency pipeline so read data returns to its owner.
module mem_port_arbiter #(
  parameter int         LATENCY     = 2,
  parameter logic [2:0] STALL_STAGE = 3'd3,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [14:0]      addr0_i,
  input  logic [14:0]      addr1_i,
  input  logic [15:0]      wdata0_i,
  input  logic [15:0]      wdata1_i,
  output logic [1:0]       gnt_o,
  output logic [2:0]       stall0_o,
  output logic [2:0]       stall1_o,
  output logic [1:0]       rvalid_o,
  output logic [15:0]      rdata_o,
  output logic [14:0]      mem_raddr_o,
  input  logic [15:0]      mem_rdata_i,
  output logic             mem_wen_o,
  output logic [14:0]      mem_waddr_o,
  output logic [15:0]      mem_wdata_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic [1:0]  req_v;
  logic        prio_ptr;
  logic        win;
  logic        any_gnt;
  logic        w_we;
  logic [14:0] w_addr;
  logic [15:0] w_wdata;
  tag_t        push;
  tag_t [LATENCY:1] tag_pipe;

  // An unknown request bit fails the equality test and is treated as idle.
  always_comb begin
    req_v = 2'b00;
    for (int i = 0; i < 2; i++)
      if (req_i[i] == 1'b1) req_v[i] = 1'b1;
    if (reset) req_v = 2'b00;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_v)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_ptr ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  assign win     = gnt_o[1];
  assign any_gnt = |gnt_o;

  assign stall0_o = (req_v[0] & ~gnt_o[0]) ? STALL_STAGE : 3'd0;
  assign stall1_o = (req_v[1] & ~gnt_o[1]) ? STALL_STAGE : 3'd0;

  assign w_we    = win ? we_i[1]  : we_i[0];
  assign w_addr  = win ? addr1_i  : addr0_i;
  assign w_wdata = win ? wdata1_i : wdata0_i;

  assign mem_wen_o   = any_gnt & w_we;
  assign mem_waddr_o = mem_wen_o ? w_addr  : 15'd0;
  assign mem_wdata_o = mem_wen_o ? w_wdata : 16'd0;
  assign mem_raddr_o = (any_gnt & ~w_we) ? w_addr : 15'd0;

  assign push.vld = any_gnt & ~w_we;
  assign push.id  = win;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_ptr       <= 1'b0;
      tag_pipe       <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (any_gnt) prio_ptr <= ~win;
      tag_pipe[1] <= push;
      for (int s = 2; s <= LATENCY; s++)
        tag_pipe[s] <= tag_pipe[s-1];
      if (req_v == 2'b11 && !(&conflict_cnt_o))
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end

  always_comb begin
    rvalid_o = 2'b00;
    rvalid_o[tag_pipe[LATENCY].id] = tag_pipe[LATENCY].vld;
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a two-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i, we_i;
  logic [14:0] addr0_i, addr1_i;
  logic [15:0] wdata0_i, wdata1_i;
  logic [15:0] mem_rdata_i;

  logic [1:0]  gnt_o, rvalid_o;
  logic [2:0]  stall0_o, stall1_o;
  logic [15:0] rdata_o, mem_wdata_o;
  logic [14:0] mem_raddr_o, mem_waddr_o;
  logic        mem_wen_o;
  logic [15:0] conflict_cnt_o;

  logic [1:0]  g4, rv4;
  logic [2:0]  s04, s14;
  logic [15:0] rd4, wd4;
  logic [14:0] ra4, wa4;
  logic        we4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .stall0_o(stall0_o), .stall1_o(stall1_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i), .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .conflict_cnt_o(conflict_cnt_o));

  mem_port_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(g4), .stall0_o(s04), .stall1_o(s14),
    .rvalid_o(rv4), .rdata_o(rd4), .mem_raddr_o(ra4),
    .mem_rdata_i(mem_rdata_i), .mem_wen_o(we4), .mem_waddr_o(wa4),
    .mem_wdata_o(wd4), .conflict_cnt_o(cnt4));

  // Memory model: two-cycle read latency, write visible from the next cycle.
  logic [15:0] mem [0:255];
  logic [14:0] ra_d1, ra_d2;
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h11] <= 16'hCAFE;
    end else if (mem_wen_o) begin
      mem[mem_waddr_o[7:0]] <= mem_wdata_o;
    end
    ra_d1 <= mem_raddr_o;
    ra_d2 <= ra_d1;
  end
  assign mem_rdata_i = mem[ra_d2[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req_i = 2'b00; we_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    nxt(); nxt();

    // Reset state, requests ignored while reset is high
    req_i = 2'b11; #2;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_stall0", 32'(stall0_o), 32'h0);
    chk("rst_stall1", 32'(stall1_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_wen", 32'(mem_wen_o), 32'h0);
    chk("rst_raddr", 32'(mem_raddr_o), 32'h0);
    nxt(); #2;
    chk("rst_cnt", 32'(conflict_cnt_o), 32'h0);
    reset = 1'b0; req_i = 2'b00; nxt();

    // Single load, core 0
    req_i = 2'b01; we_i = 2'b00; addr0_i = 15'h0010; #2;
    chk("t1_gnt", 32'(gnt_o), 32'h1);
    chk("t1_stall0", 32'(stall0_o), 32'h0);
    chk("t1_raddr", 32'(mem_raddr_o), 32'h10);
    nxt();
    req_i = 2'b00; #2;
    chk("t1_rvalid_early", 32'(rvalid_o), 32'h0);
    nxt(); #2;
    chk("t1_rvalid", 32'(rvalid_o), 32'h1);
    chk("t1_rdata", 32'(rdata_o), 32'hBEEF);
    nxt(); #2;
    chk("t1_rvalid_late", 32'(rvalid_o), 32'h0);

    // Four conflicting loads after reset
    reset = 1'b1; nxt(); reset = 1'b0;
    req_i = 2'b11; addr0_i = 15'h0010; addr1_i = 15'h0011;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("t2_gnt%0d", k), 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t2_stall0_%0d", k), 32'(stall0_o), (k % 2 == 0) ? 32'h0 : 32'h3);
      chk($sformatf("t2_stall1_%0d", k), 32'(stall1_o), (k % 2 == 0) ? 32'h3 : 32'h0);
      if (k >= 2) begin
        chk($sformatf("t2_rvalid%0d", k), 32'(rvalid_o), (k % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("t2_rdata%0d", k), 32'(rdata_o), (k % 2 == 0) ? 32'hBEEF : 32'hCAFE);
      end
      nxt();
    end
    req_i = 2'b00; #2;
    chk("t2_rvalid4", 32'(rvalid_o), 32'h1);
    chk("t2_rdata4", 32'(rdata_o), 32'hBEEF);
    chk("t2_cnt", 32'(conflict_cnt_o), 32'd4);
    chk("t2_cnt4", 32'(cnt4), 32'd4);
    nxt(); #2;
    chk("t2_rvalid5", 32'(rvalid_o), 32'h2);
    chk("t2_rdata5", 32'(rdata_o), 32'hCAFE);
    nxt();

    // Core 0 store races core 1 load to the same address
    req_i = 2'b11; we_i = 2'b01; addr0_i = 15'h0020; wdata0_i = 16'h1234; addr1_i = 15'h0020; #2;
    chk("t3_gnt0", 32'(gnt_o), 32'h1);
    chk("t3_wen0", 32'(mem_wen_o), 32'h1);
    chk("t3_waddr", 32'(mem_waddr_o), 32'h20);
    chk("t3_wdata", 32'(mem_wdata_o), 32'h1234);
    chk("t3_stall1", 32'(stall1_o), 32'h3);
    nxt();
    req_i = 2'b10; we_i = 2'b00; #2;
    chk("t3_gnt1", 32'(gnt_o), 32'h2);
    chk("t3_wen1", 32'(mem_wen_o), 32'h0);
    chk("t3_raddr", 32'(mem_raddr_o), 32'h20);
    chk("t3_stall1b", 32'(stall1_o), 32'h0);
    nxt();
    req_i = 2'b00; #2;
    chk("t3_rvalid2", 32'(rvalid_o), 32'h0);
    nxt(); #2;
    chk("t3_rvalid3", 32'(rvalid_o), 32'h2);
    chk("t3_rdata", 32'(rdata_o), 32'h1234);
    chk("t3_cnt", 32'(conflict_cnt_o), 32'd5);
    nxt();

    // Core 1 alone keeps winning; pointer returns to core 0
    req_i = 2'b10; addr1_i = 15'h0011;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("t4_gnt%0d", k), 32'(gnt_o), 32'h2);
      chk($sformatf("t4_stall1_%0d", k), 32'(stall1_o), 32'h0);
      nxt();
    end
    req_i = 2'b11; addr0_i = 15'h0010; #2;
    chk("t4_tie", 32'(gnt_o), 32'h1);
    nxt();
    req_i = 2'b00; nxt(); nxt(); nxt();

    // Reset right after a load discards its tag
    req_i = 2'b01; addr0_i = 15'h0010; #2;
    chk("t5_gnt", 32'(gnt_o), 32'h1);
    nxt();
    reset = 1'b1; req_i = 2'b00; #2;
    chk("t5_rvalid1", 32'(rvalid_o), 32'h0);
    nxt();
    reset = 1'b0; #2;
    chk("t5_rvalid2", 32'(rvalid_o), 32'h0);
    nxt(); #2;
    chk("t5_rvalid3", 32'(rvalid_o), 32'h0);
    nxt();
    req_i = 2'b11; #2;
    chk("t5_tie", 32'(gnt_o), 32'h1);
    nxt(); req_i = 2'b00;

    // Conflict counter saturation on the narrow instance
    reset = 1'b1; nxt(); reset = 1'b0;
    req_i = 2'b11;
    repeat (14) nxt();
    #2;
    chk("t6_cnt4_14", 32'(cnt4), 32'hE);
    repeat (5) nxt();
    req_i = 2'b00; #2;
    chk("t6_cnt4_sat", 32'(cnt4), 32'hF);
    chk("t6_cnt16", 32'(conflict_cnt_o), 32'd19);
    nxt(); #2;
    chk("t6_cnt4_hold", 32'(cnt4), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port (read address/data plus write enable/address/data) between two pipelined cores.
- Grants one load or store per cycle using round-robin priority.
- Drives each losing core's stall_num input, so the core freezes at the execute0 boundary.
- Returns read data to the owning core after the fixed memory latency.
- Sits between the core instances and the memory model, in place of a direct core-to-memory connection.

Parameters:
LATENCY, 2, cycles from memory read address to valid read data (matches the E0-to-WB distance in the core).
STALL_STAGE, 3, stall_num value driven to a denied requester (freezes fetch0..execute0).
CNT_W, 16, width of the saturating conflict counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_i  in  2  per-core request valid (bit i = core i)
we_i  in  2  per-core 1=store, 0=load
addr0_i  in  15  core 0 word address [15:1]
addr1_i  in  15  core 1 word address [15:1]
wdata0_i  in  16  core 0 store data
wdata1_i  in  16  core 1 store data
gnt_o  out  2  one-hot grant, combinational, same cycle as request
stall0_o  out  3  stall_num to core 0
stall1_o  out  3  stall_num to core 1
rvalid_o  out  2  read data valid for core i
rdata_o  out  16  read data, broadcast to both cores
mem_raddr_o  out  15  memory read word address
mem_rdata_i  in  16  memory read data, LATENCY cycles after mem_raddr_o
mem_wen_o  out  1  memory write enable
mem_waddr_o  out  15  memory write word address
mem_wdata_o  out  16  memory write data
conflict_cnt_o  out  CNT_W  count of cycles with both requests asserted

Behaviour:
- Reset state (synchronous):
  - prio_ptr=0, so core 0 wins the first tie.
  - Response pipeline valids cleared; conflict_cnt_o=0.
  - gnt_o=0, stall*_o=0, rvalid_o=0, mem_wen_o=0.
  - While reset is high, grant is forced to 0 and no request is forwarded.
- Grant (combinational):
  - No request: gnt_o=0.
  - Exactly one request: grant it, regardless of prio_ptr.
  - Both requests: grant core prio_ptr.
- Pointer update: on any grant of core g, prio_ptr <= ~g at the next edge. With no grant, prio_ptr holds.
- Stall outputs: stalli_o = STALL_STAGE when req_i[i] & ~gnt_o[i], else 0. Combinational, same cycle as the denial.
- Requester obligation: hold req/we/addr/wdata stable while stalled. The arbiter keeps no copy of a denied request.
- Memory drive, granted store:
  - mem_wen_o=1, mem_waddr_o=addr of winner, mem_wdata_o=wdata of winner.
  - No read tag is pushed.
- Memory drive, granted load:
  - mem_wen_o=0, mem_raddr_o=addr of winner.
  - Push tag {valid=1, id=g} into the pipeline.
- Idle cycle: mem_raddr_o=0, mem_wen_o=0, and a tag with valid=0 is pushed.
- Response pipeline:
  - LATENCY-deep shift register of {valid, id}, advancing every cycle. It never stalls: memory latency is fixed.
  - At the tail, rvalid_o[id] = valid; rdata_o = mem_rdata_i, passed straight through with no register.
  - A load granted in cycle t gives rvalid in cycle t+LATENCY.
  - Back-to-back loads from alternating cores return in the same order, one per cycle.
- Conflict counter: increments on each cycle with req_i==2'b11. Saturates at all-ones and does not wrap.
- Reset mid-operation: in-flight tags are discarded. No rvalid is asserted for loads granted before reset, even if memory still returns data.
- Ordering:
  - The arbiter never reorders accesses.
  - A store granted in cycle t is visible to a load granted in cycle t+1 or later; the memory model guarantees this.
- Unknown inputs: an X on req_i is treated as no request, so no grant and no stall.
- Sizing: grant mux, pointer, tag shift register and counter only, within 120-400 RTL lines.

Test Plan:
- Reset, then single load, core 0, addr=15'h0010, memory returns 16'hBEEF → gnt_o=01, stall0_o=0, rvalid_o=01 exactly 2 cycles later with rdata_o=16'hBEEF.
- Both cores load for 4 consecutive cycles after reset → grants alternate 01,10,01,10; the denied core sees stall=3 each cycle; rvalid alternates 01,10,01,10 starting 2 cycles after the first grant; conflict_cnt_o=4.
- Core 0 stores 16'h1234 to 15'h0020 while core 1 loads 15'h0020, with prio_ptr=0 → cycle 0: mem_wen_o=1, stall1_o=3; cycle 1: core 1 granted, rvalid_o=10 at cycle 3 with rdata 16'h1234.
- Core 1 alone requests 3 cycles with prio_ptr=0 → granted every cycle, no stall; prio_ptr=0 after each grant.
- Load granted, reset asserted the next cycle for 1 cycle → rvalid_o stays 00 for all following cycles; prio_ptr=0.
- Force 2^CNT_W+3 conflict cycles with CNT_W=4 (19 cycles) → conflict_cnt_o holds at 4'hF.
